// File: rtl/qbus_slave_seq.sv
// qbus_slave_seq: QBUS programmed-I/O slave sequencer (DATI, DATO, DATOB, DATIO).
// Synchronises the bus strobes and decodes the I/O-page address. It issues
// one-cycle register read/write requests and drives TRPLY and the DAL
// direction control.
// Optional feature: define QSLAVE_BYTE_WRITE_EN to honour WTBT (DATOB byte
// writes). Without it, every write is a full-word write.
// DESKEW must be at least 1.
module qbus_slave_seq #(
  parameter logic [12:0] BASE_ADDR = 13'o12150,
  parameter int          NREGS     = 2,
  parameter int          DESKEW    = 2,
  parameter int          ACK_TMO   = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RSYNC,
  input  logic        RDIN,
  input  logic        RDOUT,
  input  logic        RWTBT,
  input  logic        RBS7,
  input  logic        RINIT,
  inout  wire  [21:0] DAL,
  output logic        DALtx,
  output logic        TRPLY,
  output logic [2:0]  reg_sel,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [1:0]  reg_be,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  input  logic        reg_ack
);

  localparam int             CW       = 8;
  localparam logic [CW-1:0]  TMO_LAST = CW'(ACK_TMO - 1);
  localparam logic [CW-1:0]  DSK_LAST = CW'(DESKEW - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, RD_WAIT, RD_DSK, RD_RPLY, RD_DONE, WR_WAIT, WR_RPLY, WAIT_END
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [15:0]     rd_data;
  logic [3:0]      meta, sync, prev;
  logic [11:0]     off;
  logic            match;
  logic            sync_rise, sync_fall, din_rise, din_fall, dout_rise, dout_fall;
  logic            dout_s, init_s;
`ifdef QSLAVE_BYTE_WRITE_EN
  logic            addr0;
  logic            unused;
  assign unused = ^DAL[21:16];
`else
  logic            unused;
  assign unused = ^{DAL[21:16], RWTBT};
`endif

  // Read data goes back onto the bus only while this slave owns DAL.
  assign DAL = DALtx ? {6'b0, rd_data} : 22'bz;

  // Word offset of the presented address from register 0. A wrap below the base
  // address produces a large offset, so the range test also rejects it.
  assign off   = DAL[12:1] - BASE_ADDR[12:1];
  assign match = RBS7 && (off < 12'(NREGS));

  assign sync_rise = sync[0] & ~prev[0];
  assign sync_fall = ~sync[0] & prev[0];
  assign din_rise  = sync[1] & ~prev[1];
  assign din_fall  = ~sync[1] & prev[1];
  assign dout_rise = sync[2] & ~prev[2];
  assign dout_fall = ~sync[2] & prev[2];
  assign dout_s    = sync[2];
  assign init_s    = sync[3];

  // Two-flop synchronisers for the asynchronous strobes plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= {RINIT, RDOUT, RDIN, RSYNC};
      sync <= meta;
      prev <= sync;
    end
  end

  // Slave cycle sequencer; all bus and register-file outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_data   <= '0;
      DALtx     <= 1'b0;
      TRPLY     <= 1'b0;
      reg_sel   <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_be    <= '0;
      reg_wdata <= '0;
`ifdef QSLAVE_BYTE_WRITE_EN
      addr0     <= 1'b0;
`endif
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      if (init_s) begin
        state     <= IDLE;
        cnt       <= '0;
        DALtx     <= 1'b0;
        TRPLY     <= 1'b0;
        reg_sel   <= '0;
        reg_be    <= '0;
        reg_wdata <= '0;
      end else if (state != IDLE && sync_fall) begin
        // The master ended the cycle, so release the bus at once whatever phase it was in.
        state <= IDLE;
        DALtx <= 1'b0;
        TRPLY <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sync_rise) begin
              if (match) begin
                reg_sel <= off[2:0];
`ifdef QSLAVE_BYTE_WRITE_EN
                addr0   <= DAL[0];
`endif
                state   <= ADDR;
              end else begin
                state <= WAIT_END;
              end
            end
          end
          ADDR: begin
            if (din_rise) begin
              reg_rd <= 1'b1;
              cnt    <= '0;
              state  <= RD_WAIT;
            end else if (dout_rise) begin
              reg_wr <= 1'b1;
              cnt    <= '0;
              state  <= WR_WAIT;
`ifdef QSLAVE_BYTE_WRITE_EN
              if (RWTBT) begin
                reg_be    <= addr0 ? 2'b10 : 2'b01;
                reg_wdata <= addr0 ? {DAL[15:8], 8'h00} : {8'h00, DAL[7:0]};
              end else begin
                reg_be    <= 2'b11;
                reg_wdata <= DAL[15:0];
              end
`else
              reg_be    <= 2'b11;
              reg_wdata <= DAL[15:0];
`endif
            end
          end
          RD_WAIT: begin
            if (reg_ack) begin
              // A master already driving DOUT means the bus is not ours to drive; drop the cycle.
              if (dout_s) begin
                state <= WAIT_END;
              end else begin
                rd_data <= reg_rdata;
                DALtx   <= 1'b1;
                cnt     <= '0;
                state   <= RD_DSK;
              end
            end else if (cnt == TMO_LAST) begin
              state <= WAIT_END;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RD_DSK: begin
            if (cnt == DSK_LAST) begin
              TRPLY <= 1'b1;
              state <= RD_RPLY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RD_RPLY: begin
            if (din_fall) begin
              TRPLY <= 1'b0;
              state <= RD_DONE;
            end
          end
          RD_DONE: begin
            // The address stays latched so that a DATIO write phase can follow.
            DALtx <= 1'b0;
            state <= ADDR;
          end
          WR_WAIT: begin
            if (reg_ack) begin
              TRPLY <= 1'b1;
              state <= WR_RPLY;
            end else if (cnt == TMO_LAST) begin
              state <= WAIT_END;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WR_RPLY: begin
            if (dout_fall) begin
              TRPLY <= 1'b0;
              state <= WAIT_END;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule
